// File: rtl/counter_pkg.sv
// Shared definitions for the event-counter read path: FSM encoding,
// default widths and the byte-lane offset helper used by the snapshot mux.
package counter_pkg;
  localparam int COUNTER_W = 32;
  localparam int BYTE_W    = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Bit offset of the shadow byte presented for a given beat index.
  function automatic int byte_offset(input int idx, input int nbytes,
                                     input int byte_w, input bit msb_first);
    return (msb_first ? (nbytes - 1 - idx) : idx) * byte_w;
  endfunction
endpackage

// File: rtl/counter_snapshot_reader.sv
// Captures the live event counter into a shadow register on request and
// streams it out as BYTE_W beats over valid/ready. Optionally clears the
// counter on the capture edge so consecutive snapshots never overlap.
module counter_snapshot_reader
  import counter_pkg::*;
#(
  parameter int WIDTH         = COUNTER_W,
  parameter int BYTE_W        = counter_pkg::BYTE_W,
  parameter int CLEAR_ON_READ = 0,
  parameter int MSB_FIRST     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [WIDTH-1:0]  counter,
  output logic              rst_counter,
  output logic              busy,
  output logic              req_dropped,
  output logic [BYTE_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);
  localparam int NBYTES = WIDTH / BYTE_W;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  if (WIDTH % BYTE_W != 0) begin : g_bad_width
    $error("counter_snapshot_reader: WIDTH must be a multiple of BYTE_W");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d;
  logic               drop_q, drop_d;
  logic               last_beat;
  logic [WIDTH-1:0]   shifted;

  assign last_beat = (idx_q == IDX_W'(NBYTES - 1));

  // State register plus shadow, beat index and sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      drop_q   <= drop_d;
    end
  end

  // Next-state: accept in IDLE, walk the bytes in SEND, drop requests while busy.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    drop_d   = drop_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          shadow_d = counter;
          idx_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (req) drop_d = 1'b1;
        if (m_ready) begin
          if (last_beat) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: beat mux from the shadow, handshake flags and the clear strobe.
  always_comb begin
    shifted     = shadow_q >> byte_offset(int'(idx_q), NBYTES, BYTE_W, MSB_FIRST != 0);
    m_data      = shifted[BYTE_W-1:0];
    m_valid     = (state_q == SEND);
    m_last      = (state_q == SEND) && last_beat;
    busy        = (state_q == SEND);
    req_dropped = drop_q;
    // Clear lands on the capture edge; the counter gives clear priority,
    // so an increment on that same edge is deliberately lost.
    rst_counter = req && (state_q == IDLE) && (CLEAR_ON_READ != 0) && !rst;
  end

`ifdef FORMAL
  logic [31:0] f_beats_q;

  // Beats transferred since the last accepted request.
  always_ff @(posedge clk) begin
    if (rst)                                f_beats_q <= '0;
    else if (req && state_q == IDLE)        f_beats_q <= '0;
    else if (m_valid && m_ready)            f_beats_q <= f_beats_q + 1;
  end

  a_hold:  assert property (@(posedge clk) disable iff (rst)
             (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_last)));
  a_last:  assert property (@(posedge clk) disable iff (rst) m_last |-> m_valid);
  a_clr:   assert property (@(posedge clk) disable iff (rst) rst_counter |-> (state_q == IDLE));
  a_count: assert property (@(posedge clk) disable iff (rst)
             (m_valid && m_ready && m_last) |-> (f_beats_q == 32'(NBYTES - 1)));
`endif
endmodule

// File: tb/tb_counter_snapshot_reader.sv
// Directed bench for counter_snapshot_reader: three instances cover MSB-first,
// LSB-first and clear-on-read builds; the bench models the counter block.
module tb_counter_snapshot_reader;
  logic        clk;
  logic        rst;
  logic [2:0]  req, rdy, inc;
  logic [2:0]  rstc, bsy, drp, mv, ml;
  logic [31:0] cnt [3];
  logic [7:0]  md  [3];
  int          n_chk, n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  counter_snapshot_reader #(.WIDTH(32), .BYTE_W(8), .CLEAR_ON_READ(0), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .req(req[0]), .counter(cnt[0]), .rst_counter(rstc[0]),
    .busy(bsy[0]), .req_dropped(drp[0]), .m_data(md[0]), .m_valid(mv[0]),
    .m_ready(rdy[0]), .m_last(ml[0]));

  counter_snapshot_reader #(.WIDTH(32), .BYTE_W(8), .CLEAR_ON_READ(0), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .req(req[1]), .counter(cnt[1]), .rst_counter(rstc[1]),
    .busy(bsy[1]), .req_dropped(drp[1]), .m_data(md[1]), .m_valid(mv[1]),
    .m_ready(rdy[1]), .m_last(ml[1]));

  counter_snapshot_reader #(.WIDTH(32), .BYTE_W(8), .CLEAR_ON_READ(1), .MSB_FIRST(1)) u_cor (
    .clk(clk), .rst(rst), .req(req[2]), .counter(cnt[2]), .rst_counter(rstc[2]),
    .busy(bsy[2]), .req_dropped(drp[2]), .m_data(md[2]), .m_valid(mv[2]),
    .m_ready(rdy[2]), .m_last(ml[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; the counter model clears on the strobe seen at the edge.
  task automatic step();
    logic rc;
    rc = rstc[2];
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (i == 2 && rc)  cnt[i] = '0;
      else if (inc[i])   cnt[i] = cnt[i] + 1;
    end
  endtask

  // One snapshot with ready held high; exp lists the bytes in emission order.
  // drop_at >= 0 raises req again on that beat.
  task automatic run_snap(input int i, input logic [31:0] exp, input int drop_at, input string tag);
    req[i] = 1'b1;
    #1;
    chk({tag, "_accept_clr"}, 32'(rstc[i]), (i == 2) ? 32'd1 : 32'd0);
    chk({tag, "_accept_vld"}, 32'(mv[i]), 32'd0);
    step();
    for (int b = 0; b < 4; b++) begin
      req[i] = (b == drop_at);
      #1;
      chk($sformatf("%s_b%0d_vld", tag, b), 32'(mv[i]), 32'd1);
      chk($sformatf("%s_b%0d_dat", tag, b), 32'(md[i]), 32'(exp[31-8*b -: 8]));
      chk($sformatf("%s_b%0d_lst", tag, b), 32'(ml[i]), (b == 3) ? 32'd1 : 32'd0);
      chk($sformatf("%s_b%0d_bsy", tag, b), 32'(bsy[i]), 32'd1);
      chk($sformatf("%s_b%0d_clr", tag, b), 32'(rstc[i]), 32'd0);
      step();
      req[i] = 1'b0;
    end
    #1;
    chk({tag, "_end_vld"}, 32'(mv[i]), 32'd0);
    chk({tag, "_end_bsy"}, 32'(bsy[i]), 32'd0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; req = '0; rdy = '1; inc = '0;
    for (int i = 0; i < 3; i++) cnt[i] = '0;
    @(negedge clk);
    step();

    // Reset state, and rst beats req on the clear strobe.
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_vld%0d", i), 32'(mv[i]), 32'd0);
      chk($sformatf("rst_bsy%0d", i), 32'(bsy[i]), 32'd0);
      chk($sformatf("rst_drp%0d", i), 32'(drp[i]), 32'd0);
      chk($sformatf("rst_lst%0d", i), 32'(ml[i]), 32'd0);
    end
    req[2] = 1'b1;
    #1;
    chk("rst_prio_clr", 32'(rstc[2]), 32'd0);
    step();
    req[2] = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_prio_vld", 32'(mv[2]), 32'd0);

    // 1. MSB order, then back-to-back accept in the first idle cycle.
    cnt[0] = 32'h12345678;
    run_snap(0, 32'h12345678, -1, "msb");
    cnt[0] = 32'h89ABCDEF;
    run_snap(0, 32'h89ABCDEF, -1, "b2b");

    // 2. LSB order; also a request on the last beat is dropped.
    cnt[1] = 32'hA1B2C3D4;
    run_snap(1, 32'hD4C3B2A1, 3, "lsb");
    chk("lsb_drop_last", 32'(drp[1]), 32'd1);

    // 3. Backpressure on beat 2 while the counter keeps running.
    cnt[0] = 32'h12345678; inc[0] = 1'b1;
    req[0] = 1'b1; #1; step(); req[0] = 1'b0;
    #1; chk("bp_b0", 32'(md[0]), 32'h12); step();
    rdy[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_hold%0d_vld", k), 32'(mv[0]), 32'd1);
      chk($sformatf("bp_hold%0d_dat", k), 32'(md[0]), 32'h34);
      chk($sformatf("bp_hold%0d_lst", k), 32'(ml[0]), 32'd0);
      step();
    end
    rdy[0] = 1'b1;
    #1; chk("bp_b1", 32'(md[0]), 32'h34); step();
    #1; chk("bp_b2", 32'(md[0]), 32'h56); step();
    #1; chk("bp_b3", 32'(md[0]), 32'h78); chk("bp_b3_lst", 32'(ml[0]), 32'd1); step();
    #1; chk("bp_end_vld", 32'(mv[0]), 32'd0);
    inc[0] = 1'b0;

    // 4. Clear-on-read: 100 is reported, then the count since the clear.
    cnt[2] = 32'd100; inc[2] = 1'b1;
    run_snap(2, 32'h00000064, -1, "cor1");
    run_snap(2, 32'h00000004, -1, "cor2");
    inc[2] = 1'b0;

    // 5. Dropped request during beat 1: stream unchanged, exactly 4 beats.
    chk("drop_pre", 32'(drp[0]), 32'd0);
    cnt[0] = 32'hCAFEF00D;
    run_snap(0, 32'hCAFEF00D, 0, "drop");
    chk("drop_sticky", 32'(drp[0]), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step(); #1;
      chk($sformatf("drop_idle%0d", k), 32'(mv[0]), 32'd0);
    end
    chk("drop_hold", 32'(drp[0]), 32'd1);
    cnt[2] = 32'h00000055;
    run_snap(2, 32'h00000055, 1, "cordrop");
    chk("cordrop_sticky", 32'(drp[2]), 32'd1);

    // 6. Reset after two beats transferred, then a fresh full snapshot.
    cnt[0] = 32'h01020304;
    req[0] = 1'b1; #1; step(); req[0] = 1'b0;
    #1; chk("mid_b0", 32'(md[0]), 32'h01); step();
    #1; chk("mid_b1", 32'(md[0]), 32'h02); step();
    rst = 1'b1; #1; step(); rst = 1'b0;
    #1;
    chk("mid_vld", 32'(mv[0]), 32'd0);
    chk("mid_bsy", 32'(bsy[0]), 32'd0);
    chk("mid_drp", 32'(drp[0]), 32'd0);
    chk("mid_lst", 32'(ml[0]), 32'd0);
    chk("mid_drp_lsb", 32'(drp[1]), 32'd0);
    cnt[0] = 32'h0A0B0C0D;
    run_snap(0, 32'h0A0B0C0D, -1, "post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/counter_snapshot_reader.md
Name: counter_snapshot_reader

Overview:
Read side of the free-running event counter. On a single-cycle request it captures the counter value into a shadow register and streams it out as bytes over a valid/ready handshake. It can optionally clear the counter in the same cycle as the capture (clear-on-read) by driving the counter's rst_counter input. It sits between the counter and a byte-wide debug/telemetry link.

Parameters:
WIDTH, 32, counter width; must be an integer multiple of BYTE_W (elaboration-time assertion)
BYTE_W, 8, output beat width
CLEAR_ON_READ, 0, 1 = pulse rst_counter on each accepted request
MSB_FIRST, 1, 1 = most-significant byte sent first; 0 = least-significant first

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
req  input  1  snapshot request, sampled each cycle
counter  input  WIDTH  live counter value
rst_counter  output  1  clear strobe to the counter block
busy  output  1  snapshot in flight
req_dropped  output  1  sticky: a request arrived while busy
m_data  output  BYTE_W  stream data
m_valid  output  1  stream valid
m_ready  input  1  stream ready
m_last  output  1  final beat of a snapshot

Behaviour:
- NBYTES = WIDTH/BYTE_W; byte index register is clog2(NBYTES) bits (minimum 1).
- States: IDLE, SEND.
- Reset values: state IDLE, index 0, shadow 0, m_valid 0, m_last 0, busy 0, req_dropped 0, rst_counter 0.
- IDLE:
  - req=1 accepts the request. At that clock edge, shadow <= counter, index <= 0, state <= SEND.
  - busy and m_valid go to 1 on the following cycle. Latency is 1 cycle from req to the first beat valid.
- rst_counter is combinational: req & (state==IDLE) & CLEAR_ON_READ & ~rst.
  - The counter clears at the same edge the shadow captures, so no count is double-reported.
  - An increment coinciding with that edge is lost, because the counter gives clear priority. This is intended.
- SEND:
  - m_valid=1.
  - m_data = shadow byte selected by index: byte (NBYTES-1-index) if MSB_FIRST, else byte index.
  - m_last = (index==NBYTES-1).
  - A beat transfers when m_valid & m_ready. On a non-last transfer, index increments. On the last transfer, state <= IDLE and index <= 0.
  - While m_valid & ~m_ready, m_data and m_last must hold stable. The shadow is never updated in SEND.
- busy = (state==SEND).
- req while in SEND is ignored and sets req_dropped. req_dropped clears only on rst.
- req in the cycle of the last transfer is also dropped, since state is still SEND.
- Back-to-back: req in the first IDLE cycle after the last beat is accepted. Minimum gap between snapshots is 1 idle cycle.
- Reset mid-stream: next cycle returns to IDLE with m_valid=0 and the shadow cleared. A partial snapshot is not resumed.
- rst has priority over req; no rst_counter pulse is issued during rst.
- Formal properties (under FORMAL, disabled during rst):
  - m_valid & ~m_ready implies m_valid, m_data and m_last are stable on the next cycle.
  - m_last implies m_valid.
  - rst_counter implies state IDLE.
  - Exactly NBYTES transfers occur per accepted request.

Decomposition:
- Shared package counter_pkg holds:
  - the state enum (IDLE, SEND) as a typedef
  - default width localparams: COUNTER_W=32, BYTE_W=8
  - a byte-index function giving shadow bit offset from index and MSB_FIRST
- No sub-module. The FSM, shadow register and byte mux fit naturally in one module.

Test Plan:
1. Basic MSB order. counter=0x12345678, req pulse, m_ready=1 → beats 0x12, 0x34, 0x56, 0x78 on 4 consecutive cycles starting 1 cycle after req. m_last only on 0x78; busy=0 on the next cycle.
2. LSB order. MSB_FIRST=0, counter=0xA1B2C3D4 → beats 0xD4, 0xC3, 0xB2, 0xA1.
3. Backpressure and stability. The counter keeps incrementing during the stream.
   - m_ready=0 for 3 cycles on beat 2 → m_data holds 0x34 and m_valid holds 1 throughout.
   - The stream completes with the original snapshot values.
4. Clear-on-read. CLEAR_ON_READ=1, counter=100, req → rst_counter=1 for exactly that one cycle.
   - The counter reads 0 the next cycle; the stream carries 100 (0x00000064).
   - A second req later yields the count since the clear.
5. Dropped request. req again during beat 1 → req_dropped=1 and the stream is unchanged. Only 4 beats are sent and no rst_counter pulse occurs.
6. Reset mid-stream. rst asserted after beat 2 is transferred → m_valid=0, busy=0 and req_dropped=0 the next cycle. A new req then produces a full 4-beat snapshot of the current counter.
